reg_file: RTL and testbench
===========================

# reg_file

Two-read/one-write 32-entry general-purpose register file for the RV32I datapath. Sits directly upstream of the ALU: its two read ports drive the ALU `A` and `B` operands, and its write port takes the write-back result (ALU output or load data). Register x0 is hardwired to zero. An optional write-to-read bypass makes a same-cycle write visible on the read ports.

## Interface
- `N`, 32, data width of each register and of every data port.
- `BYPASS`, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only.

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `rs1_addr`  input  5  read port 1 register index
- `rs2_addr`  input  5  read port 2 register index
- `read_data1`  output  N  contents of `rs1_addr`, drives ALU `A`
- `read_data2`  output  N  contents of `rs2_addr`, drives ALU `B`
- `reg_write`  input  1  write enable
- `rd_addr`  input  5  write register index
- `rd_data`  input  N  write data

## Operation
- Storage: 32 x N flops, x1..x31 writable; x0 has no storage, always reads 0.
- Write: on rising `clk` with `rst_n`=1, `reg_write`=1, `rd_addr`!=0 -> `regs[rd_addr]` <= `rd_data`. If `rd_addr`=0 the write is discarded without error.
- Read (combinational, both ports independent, any index including the same index on both):
  - `rst_n`=0 -> output 0.
  - address 0 -> 0 (bypass never applies to x0).
  - `BYPASS`=1, `reg_write`=1, address == `rd_addr` -> `rd_data`.
  - otherwise -> `regs[address]`.
- Reset: `rst_n` falling clears x1..x31 to 0 immediately, independent of `clk`. While `rst_n`=0 all writes are ignored and both outputs are 0.
- Reset mid-operation: a write coinciding with reset assertion is lost. The first write accepted is at the first rising edge with `rst_n` already high.
- No X propagation: every output is defined for every input combination once reset has been applied.

## Timing
- Read latency: 0 cycles (combinational from addresses, plus from `reg_write`/`rd_addr`/`rd_data` when `BYPASS`=1).
- Write latency: 1 edge. Data is visible through storage from the cycle after the write edge.
- With `BYPASS`=0, a read of the register being written in the same cycle returns the old value; the new value appears after the edge.
- Reset values: `read_data1`=0, `read_data2`=0, all registers 0.
- Critical path: read mux plus bypass compare. The ALU closes timing with the register file in the same cycle.

## Test plan
- Reset: assert `rst_n`=0 with x5 previously written to 0xDEADBEEF -> `read_data1`/`read_data2` = 0 immediately. After release, reading x5 still gives 0.
- Basic write/read: write x5=15, then write x6=10; set `rs1_addr`=5, `rs2_addr`=6 -> `read_data1`=15, `read_data2`=10. Both ports set to 5 -> both give 15.
- x0 protection: write x0=0xFFFFFFFF with `reg_write`=1 -> reading x0 on both ports gives 0, including in the write cycle with `BYPASS`=1.
- Bypass: with `BYPASS`=1, x7=3 stored, drive `reg_write`=1, `rd_addr`=7, `rd_data`=42, `rs1_addr`=7 -> `read_data1`=42 in the same cycle. With `BYPASS`=0 the same stimulus gives 3 before the edge and 42 after it.
- Write disable: `reg_write`=0, `rd_addr`=8, `rd_data`=99, x8=1 -> after the edge x8 still reads 1.
- Reset mid-operation: assert `rst_n` low between edges during a write to x9=77 -> x9 reads 0. Release `rst_n` and write x9=77 on the next edge -> x9 reads 77.

Source files
------------

// File: rtl/reg_file_if.sv
// Register file bus: two read ports feeding the ALU operands and one
// write-back port. The datapath side is the master, the register file
// is the slave.
interface reg_file_if #(
  parameter int N = 32
);
  logic [4:0]   rs1_addr;
  logic [4:0]   rs2_addr;
  logic [N-1:0] read_data1;
  logic [N-1:0] read_data2;
  logic         reg_write;
  logic [4:0]   rd_addr;
  logic [N-1:0] rd_data;

  modport master (
    output rs1_addr, rs2_addr, reg_write, rd_addr, rd_data,
    input  read_data1, read_data2
  );

  modport slave (
    input  rs1_addr, rs2_addr, reg_write, rd_addr, rd_data,
    output read_data1, read_data2
  );
endinterface

// File: rtl/reg_file.sv
// RV32I general-purpose register file: 2 combinational read ports,
// 1 synchronous write port, x0 hardwired to zero, optional same-cycle
// write-to-read bypass.
module reg_file #(
  parameter int N      = 32,
  parameter int BYPASS = 1
) (
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave bus
);

  // Entry 0 is never written, so it stays at its reset value and is
  // optimised away; reads of x0 are forced to zero regardless.
  logic [N-1:0] regs_q [32];
  logic [N-1:0] read1_d;
  logic [N-1:0] read2_d;
  logic         wr_en_d;

  // Writes to x0 are dropped here rather than stored.
  always_comb begin
    wr_en_d = bus.reg_write && (bus.rd_addr != 5'd0);
  end

  // Storage: cleared immediately on reset, one entry updated per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[bus.rd_addr] <= bus.rd_data;
    end
  end

  // Read port 1: zero in reset or for x0, bypass on address match, else storage.
  always_comb begin
    read1_d = '0;
    if (rst_n && (bus.rs1_addr != 5'd0)) begin
      if ((BYPASS != 0) && wr_en_d && (bus.rs1_addr == bus.rd_addr)) begin
        read1_d = bus.rd_data;
      end else begin
        read1_d = regs_q[bus.rs1_addr];
      end
    end
  end

  // Read port 2: same selection as port 1, independent address.
  always_comb begin
    read2_d = '0;
    if (rst_n && (bus.rs2_addr != 5'd0)) begin
      if ((BYPASS != 0) && wr_en_d && (bus.rs2_addr == bus.rd_addr)) begin
        read2_d = bus.rd_data;
      end else begin
        read2_d = regs_q[bus.rs2_addr];
      end
    end
  end

  assign bus.read_data1 = read1_d;
  assign bus.read_data2 = read2_d;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one instance with bypass, one without,
// both driven by the same stimulus.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wdata;

  int checks;
  int failures;

  reg_file_if #(.N(32)) if_byp ();
  reg_file_if #(.N(32)) if_nb ();

  assign if_byp.rs1_addr  = rs1;
  assign if_byp.rs2_addr  = rs2;
  assign if_byp.reg_write = we;
  assign if_byp.rd_addr   = rd;
  assign if_byp.rd_data   = wdata;
  assign if_nb.rs1_addr   = rs1;
  assign if_nb.rs2_addr   = rs2;
  assign if_nb.reg_write  = we;
  assign if_nb.rd_addr    = rd;
  assign if_nb.rd_data    = wdata;

  reg_file #(.N(32), .BYPASS(1)) dut_byp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_byp)
  );

  reg_file #(.N(32), .BYPASS(0)) dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; rd = a; wdata = d;
    tick();
    we = 1'b0; rd = 5'd0; wdata = '0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1; rs1 = '0; rs2 = '0; we = 1'b0; rd = '0; wdata = '0;
    #3 rst_n = 1'b0;
    #1;
    check("reset_rd1_byp", if_byp.read_data1, 32'h0);
    check("reset_rd2_nb", if_nb.read_data2, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset clears a previously written register immediately.
    write_reg(5'd5, 32'hDEADBEEF);
    rs1 = 5'd5; rs2 = 5'd5; #1;
    check("x5_written", if_byp.read_data1, 32'hDEADBEEF);
    rst_n = 1'b0; #1;
    check("async_reset_rd1", if_byp.read_data1, 32'h0);
    check("async_reset_rd2", if_nb.read_data2, 32'h0);
    tick();
    rst_n = 1'b1; #1;
    check("x5_after_reset", if_byp.read_data1, 32'h0);
    check("x5_after_reset_nb", if_nb.read_data2, 32'h0);

    // Basic write/read on both ports.
    write_reg(5'd5, 32'd15);
    write_reg(5'd6, 32'd10);
    rs1 = 5'd5; rs2 = 5'd6; #1;
    check("rd1_x5", if_byp.read_data1, 32'd15);
    check("rd2_x6", if_byp.read_data2, 32'd10);
    check("rd2_x6_nb", if_nb.read_data2, 32'd10);
    rs2 = 5'd5; #1;
    check("same_idx_rd1", if_byp.read_data1, 32'd15);
    check("same_idx_rd2", if_byp.read_data2, 32'd15);

    // x0 protection, including in the write cycle with bypass.
    rs1 = 5'd0; rs2 = 5'd0;
    we = 1'b1; rd = 5'd0; wdata = 32'hFFFFFFFF; #1;
    check("x0_write_cycle_rd1", if_byp.read_data1, 32'h0);
    check("x0_write_cycle_rd2", if_byp.read_data2, 32'h0);
    tick();
    we = 1'b0; #1;
    check("x0_after_rd1", if_byp.read_data1, 32'h0);
    check("x0_after_rd2_nb", if_nb.read_data2, 32'h0);

    // Bypass versus stored-only reads.
    write_reg(5'd7, 32'd3);
    rs1 = 5'd7; rs2 = 5'd6;
    we = 1'b1; rd = 5'd7; wdata = 32'd42; #1;
    check("bypass_rd1", if_byp.read_data1, 32'd42);
    check("bypass_other_port", if_byp.read_data2, 32'd10);
    check("nobypass_before", if_nb.read_data1, 32'd3);
    tick();
    we = 1'b0; rd = 5'd0; #1;
    check("nobypass_after", if_nb.read_data1, 32'd42);
    check("bypass_after", if_byp.read_data1, 32'd42);

    // Write disable.
    write_reg(5'd8, 32'd1);
    rs1 = 5'd8;
    we = 1'b0; rd = 5'd8; wdata = 32'd99; #1;
    check("wdis_bypass_off", if_byp.read_data1, 32'd1);
    tick();
    check("wdis_after", if_byp.read_data1, 32'd1);
    check("wdis_after_nb", if_nb.read_data1, 32'd1);

    // Reset mid-operation: the write is lost, the next one after release lands.
    rs1 = 5'd9; rs2 = 5'd9;
    we = 1'b1; rd = 5'd9; wdata = 32'd77; #1;
    rst_n = 1'b0; #1;
    check("midrst_rd1", if_byp.read_data1, 32'h0);
    tick();
    check("midrst_held_rd2", if_nb.read_data2, 32'h0);
    we = 1'b0;
    rst_n = 1'b1; #1;
    check("midrst_released_x9", if_byp.read_data1, 32'h0);
    check("midrst_released_x9_nb", if_nb.read_data1, 32'h0);
    write_reg(5'd9, 32'd77);
    #1;
    check("x9_rewrite_rd1", if_byp.read_data1, 32'd77);
    check("x9_rewrite_rd2_nb", if_nb.read_data2, 32'd77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
